// File: rtl/cache_axi_rd_arbiter_pkg.sv
// rtl/cache_axi_rd_arbiter_pkg.sv - shared encodings for the cache AXI read arbiter
package cache_axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] IC_ARID_DEF    = 4'd0;
  localparam logic [3:0] DC_ARID_DEF    = 4'd1;
  // ICache refills are always full 32-bit words
  localparam logic [2:0] IC_ARSIZE      = 3'd2;

endpackage

// File: rtl/cache_axi_rd_arbiter.sv
// rtl/cache_axi_rd_arbiter.sv - shares one AXI read channel between ICache and DCache
// One transaction outstanding at a time; round-robin on ties; R beats registered to the owner.
module cache_axi_rd_arbiter
  import cache_axi_rd_arbiter_pkg::*;
#(
  parameter logic [3:0] IC_ARID = IC_ARID_DEF,
  parameter logic [3:0] DC_ARID = DC_ARID_DEF,
  parameter int         DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_rd_req,
  input  logic [31:0]       ic_rd_addr,
  input  logic [7:0]        ic_rd_len,
  output logic              ic_rd_gnt,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [DATA_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [31:0]       dc_rd_addr,
  input  logic [7:0]        dc_rd_len,
  input  logic [2:0]        dc_rd_size,
  output logic              dc_rd_gnt,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [DATA_W-1:0] dc_ret_data,
  output logic [3:0]        arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              rd_err
);

  arb_state_t        state, state_nxt;
  owner_t            owner, last_owner;
  logic [31:0]       addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [7:0]        beat_cnt;
  logic              ret_valid_q, ret_last_q;
  logic [DATA_W-1:0] ret_data_q;
  logic              rd_err_q;
  logic              any_req, pick_dc, ar_fire, r_fire, beat_err;

  // A tie goes to whoever was not served last
  assign any_req = ic_rd_req || dc_rd_req;
  assign pick_dc = dc_rd_req && (!ic_rd_req || (last_owner == OWN_IC));
  assign ar_fire = (state == ARB_AR) && arready;
  assign r_fire  = (state == ARB_R) && rvalid;

  assign beat_err = (rresp != AXI_RESP_OKAY) || (rid != arid) ||
                    ((beat_cnt == len_q) != rlast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (any_req)          state_nxt = ARB_AR;
      ARB_AR:   if (arready)          state_nxt = ARB_R;
      ARB_R:    if (rvalid && rlast)  state_nxt = ARB_IDLE;
      default:                        state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    arvalid   = (state == ARB_AR);
    rready    = (state == ARB_R);
    ic_rd_gnt = ar_fire && (owner == OWN_IC);
    dc_rd_gnt = ar_fire && (owner == OWN_DC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= OWN_IC;
      last_owner  <= OWN_IC;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      beat_cnt    <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      if ((state == ARB_IDLE) && any_req) begin
        owner  <= pick_dc ? OWN_DC : OWN_IC;
        addr_q <= pick_dc ? dc_rd_addr : ic_rd_addr;
        len_q  <= pick_dc ? dc_rd_len : ic_rd_len;
        size_q <= pick_dc ? dc_rd_size : IC_ARSIZE;
      end
      if (ar_fire) begin
        last_owner <= owner;
        beat_cnt   <= '0;
      end
      ret_valid_q <= r_fire;
      if (r_fire) begin
        ret_data_q <= rdata;
        ret_last_q <= rlast;
        beat_cnt   <= beat_cnt + 8'd1;
        if (beat_err) rd_err_q <= 1'b1;
      end
    end
  end

  assign arid    = (owner == OWN_DC) ? DC_ARID : IC_ARID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = AXI_BURST_INCR;
  assign rd_err  = rd_err_q;

  assign ic_ret_valid = ret_valid_q && (owner == OWN_IC);
  assign dc_ret_valid = ret_valid_q && (owner == OWN_DC);
  assign ic_ret_last  = ic_ret_valid && ret_last_q;
  assign dc_ret_last  = dc_ret_valid && ret_last_q;
  assign ic_ret_data  = ret_data_q;
  assign dc_ret_data  = ret_data_q;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// tb/tb_cache_axi_rd_arbiter.sv - directed vector bench for cache_axi_rd_arbiter
module tb_cache_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_rd_req, dc_rd_req;
  logic [31:0] ic_rd_addr, dc_rd_addr;
  logic [7:0]  ic_rd_len, dc_rd_len;
  logic [2:0]  dc_rd_size;
  logic        ic_rd_gnt, ic_ret_valid, ic_ret_last;
  logic        dc_rd_gnt, dc_ret_valid, dc_ret_last;
  logic [31:0] ic_ret_data, dc_ret_data;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready, rd_err;

  cache_axi_rd_arbiter #(.IC_ARID(4'd0), .DC_ARID(4'd1), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_len(ic_rd_len),
    .ic_rd_gnt(ic_rd_gnt), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_len(dc_rd_len),
    .dc_rd_size(dc_rd_size), .dc_rd_gnt(dc_rd_gnt), .dc_ret_valid(dc_ret_valid),
    .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] ic_q[$];
  logic [32:0] dc_q[$];
  int ic_gnts = 0;
  int dc_gnts = 0;

  always @(negedge clk) begin
    if (ic_ret_valid) ic_q.push_back({ic_ret_last, ic_ret_data});
    if (dc_ret_valid) dc_q.push_back({dc_ret_last, dc_ret_data});
    if (ic_rd_gnt) ic_gnts++;
    if (dc_rd_gnt) dc_gnts++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_rd_req = 0; ic_rd_addr = 0; ic_rd_len = 0;
    dc_rd_req = 0; dc_rd_addr = 0; dc_rd_len = 0; dc_rd_size = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  // AXI slave: accept AR after ar_delay cycles, then return beats with optional gaps/faults
  task automatic slave(input logic [3:0] e_id, input logic [31:0] e_addr, input logic [7:0] e_len,
                       input logic [2:0] e_size, input int ar_delay, input int gap_max,
                       input int err_kind, input logic [31:0] dbase, output int waited);
    int nbeats;
    int gap;
    waited = 0;
    while (arvalid !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check("ar_seen", arvalid, 1);
    for (int i = 0; i < ar_delay; i++) begin
      check("ar_hold_valid", arvalid, 1);
      check("ar_hold_addr", araddr, e_addr);
      check("ar_hold_len", arlen, e_len);
      check("gnt_early", {ic_rd_gnt, dc_rd_gnt}, 0);
      tick();
    end
    arready = 1;
    #1;
    check("arid", arid, e_id);
    check("araddr", araddr, e_addr);
    check("arlen", arlen, e_len);
    check("arsize", arsize, e_size);
    check("arburst", arburst, 2'b01);
    check("ic_gnt", ic_rd_gnt, (e_id == 4'd0));
    check("dc_gnt", dc_rd_gnt, (e_id == 4'd1));
    tick();
    arready = 0;
    if (e_id == 4'd1) dc_rd_req = 0; else ic_rd_req = 0;
    #1;
    check("r_arvalid", arvalid, 0);
    check("r_rready", rready, 1);
    nbeats = (err_kind == 3) ? 5 : int'(e_len) + 1;
    for (int i = 0; i < nbeats; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) tick();
      rvalid = 1;
      rdata  = dbase + 32'(i);
      rlast  = (i == nbeats - 1);
      rresp  = (err_kind == 1 && i == 2) ? 2'b10 : 2'b00;
      rid    = (err_kind == 2) ? 4'd3 : e_id;
      tick();
      rvalid = 0; rlast = 0; rresp = 0;
    end
    #1;
    check("post_rlast_arvalid", arvalid, 0);
    check("post_rlast_rready", rready, 0);
  endtask

  task automatic verify(input string tag, input logic is_dc, input int q_own0, input int q_oth0,
                        input int g_own0, input int g_oth0, input int exp_beats,
                        input logic [31:0] dbase);
    int own_sz, oth_sz, bad;
    logic [32:0] e;
    tick();
    own_sz = is_dc ? dc_q.size() : ic_q.size();
    oth_sz = is_dc ? ic_q.size() : dc_q.size();
    check({tag, "_beats"}, own_sz - q_own0, exp_beats);
    check({tag, "_other_beats"}, oth_sz - q_oth0, 0);
    check({tag, "_gnt"}, (is_dc ? dc_gnts : ic_gnts) - g_own0, 1);
    check({tag, "_other_gnt"}, (is_dc ? ic_gnts : dc_gnts) - g_oth0, 0);
    bad = 0;
    for (int i = 0; i < exp_beats && q_own0 + i < own_sz; i++) begin
      e = is_dc ? dc_q[q_own0 + i] : ic_q[q_own0 + i];
      if (e[31:0] !== dbase + 32'(i)) bad++;
      if (e[32] !== (i == exp_beats - 1)) bad++;
    end
    check({tag, "_data_last_bad"}, bad, 0);
  endtask

  typedef struct {
    logic        is_dc;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          ar_delay;
    int          gap_max;
    int          err_kind;
    logic [31:0] dbase;
    logic [3:0]  exp_id;
    logic [2:0]  exp_size;
    int          exp_beats;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w, q_own0, q_oth0, g_own0, g_oth0, ic0, dc0;
    reset = 1;
    clear_inputs();

    vecs[0] = '{1'b0, 32'hBFC00000, 8'd7,   3'd0, 0, 0, 0, 32'h1,        4'd0, 3'd2, 8,   1'b0};
    vecs[1] = '{1'b1, 32'h80001000, 8'd0,   3'd0, 5, 0, 0, 32'hCAFE0000, 4'd1, 3'd0, 1,   1'b0};
    vecs[2] = '{1'b0, 32'h00001040, 8'd7,   3'd5, 0, 3, 0, 32'h100,      4'd0, 3'd2, 8,   1'b0};
    vecs[3] = '{1'b1, 32'h80002000, 8'd3,   3'd2, 0, 0, 1, 32'h200,      4'd1, 3'd2, 4,   1'b1};
    vecs[4] = '{1'b0, 32'h1FC00020, 8'd7,   3'd0, 1, 0, 2, 32'h300,      4'd0, 3'd2, 8,   1'b1};
    vecs[5] = '{1'b1, 32'h80003000, 8'd7,   3'd2, 0, 0, 3, 32'h400,      4'd1, 3'd2, 5,   1'b1};
    vecs[6] = '{1'b0, 32'h00008000, 8'd255, 3'd0, 0, 0, 0, 32'h1000,     4'd0, 3'd2, 256, 1'b0};

    do_reset();
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_gnts", {ic_rd_gnt, dc_rd_gnt}, 0);
    check("rst_ret_valid", {ic_ret_valid, dc_ret_valid, ic_ret_last, dc_ret_last}, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_arburst", arburst, 2'b01);
    check("rst_ar_fields", {arid, arlen, arsize}, 0);
    check("rst_araddr", araddr, 0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      q_own0 = vecs[v].is_dc ? dc_q.size() : ic_q.size();
      q_oth0 = vecs[v].is_dc ? ic_q.size() : dc_q.size();
      g_own0 = vecs[v].is_dc ? dc_gnts : ic_gnts;
      g_oth0 = vecs[v].is_dc ? ic_gnts : dc_gnts;
      if (vecs[v].is_dc) begin
        dc_rd_req = 1; dc_rd_addr = vecs[v].addr; dc_rd_len = vecs[v].len; dc_rd_size = vecs[v].size;
      end else begin
        ic_rd_req = 1; ic_rd_addr = vecs[v].addr; ic_rd_len = vecs[v].len; dc_rd_size = vecs[v].size;
      end
      slave(vecs[v].exp_id, vecs[v].addr, vecs[v].len, vecs[v].exp_size, vecs[v].ar_delay,
            vecs[v].gap_max, vecs[v].err_kind, vecs[v].dbase, w);
      verify($sformatf("vec%0d", v), vecs[v].is_dc, q_own0, q_oth0, g_own0, g_oth0,
             vecs[v].exp_beats, vecs[v].dbase);
      check($sformatf("vec%0d_rd_err", v), rd_err, vecs[v].exp_err);
      tick();
      check($sformatf("vec%0d_rd_err_sticky", v), rd_err, vecs[v].exp_err);
    end

    // Ties: DC wins first after reset, then alternates against last_owner
    do_reset();
    ic0 = ic_q.size(); dc0 = dc_q.size();
    ic_rd_req = 1; ic_rd_addr = 32'h100; ic_rd_len = 8'd1;
    dc_rd_req = 1; dc_rd_addr = 32'h200; dc_rd_len = 8'd1; dc_rd_size = 3'd3;
    slave(4'd1, 32'h200, 8'd1, 3'd3, 0, 0, 0, 32'hD0, w);
    slave(4'd0, 32'h100, 8'd1, 3'd2, 0, 0, 0, 32'hE0, w);
    check("tie1_ic_wait", w, 1);
    dc_rd_req = 1; dc_rd_addr = 32'h300; dc_rd_len = 8'd0; dc_rd_size = 3'd2;
    slave(4'd1, 32'h300, 8'd0, 3'd2, 0, 0, 0, 32'hF0, w);
    ic_rd_req = 1; ic_rd_addr = 32'h400; ic_rd_len = 8'd0;
    dc_rd_req = 1; dc_rd_addr = 32'h500; dc_rd_len = 8'd1; dc_rd_size = 3'd1;
    slave(4'd0, 32'h400, 8'd0, 3'd2, 0, 0, 0, 32'hA0, w);
    slave(4'd1, 32'h500, 8'd1, 3'd1, 0, 0, 0, 32'hB0, w);
    check("tie2_dc_wait", w, 1);
    tick();
    check("tie_ic_beats", ic_q.size() - ic0, 3);
    check("tie_dc_beats", dc_q.size() - dc0, 5);
    check("tie_rd_err", rd_err, 0);

    // Asynchronous reset in the middle of an 8-beat IC burst
    do_reset();
    ic_rd_req = 1; ic_rd_addr = 32'h2000; ic_rd_len = 8'd7;
    w = 0;
    while (arvalid !== 1'b1 && w < 50) begin tick(); w++; end
    check("mid_ar_seen", arvalid, 1);
    arready = 1;
    tick();
    arready = 0; ic_rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'h50 + 32'(i); rid = 4'd0; rlast = 0;
      tick();
    end
    rvalid = 0;
    #1;
    check("mid_ret_valid_pre", ic_ret_valid, 1);
    check("mid_rready_pre", rready, 1);
    reset = 1;
    #1;
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_ret_valid", ic_ret_valid, 0);
    tick();
    tick();
    reset = 0;
    tick();
    q_own0 = ic_q.size(); q_oth0 = dc_q.size(); g_own0 = ic_gnts; g_oth0 = dc_gnts;
    ic_rd_req = 1; ic_rd_addr = 32'h3000; ic_rd_len = 8'd3;
    slave(4'd0, 32'h3000, 8'd3, 3'd2, 0, 0, 0, 32'h60, w);
    verify("after_rst", 1'b0, q_own0, q_oth0, g_own0, g_oth0, 4, 32'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
